// File: rtl/axi_w_channel.sv
// axi_w_channel
//   AXI4 write-channel slave in front of a single-port on-chip SRAM.
//   Accepts one AW burst at a time, streams every accepted W beat straight
//   onto the SRAM write port, then answers with a single B response.
//
// Ports
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   AW*  (AWID..AWVALID/READY) burst request; only AWADDR[15:0] is used
//   W*   (WDATA..WVALID/READY) write beats
//   B*   (BID, BRESP, BVALID/BREADY) write response
//   wen, sram_wstrb, awaddr, sram_wdata
//                              SRAM write port, valid in the cycle a W beat
//                              is accepted
module axi_w_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  wen,
  output logic [3:0]            sram_wstrb,
  output logic [15:0]           awaddr,
  output logic [31:0]           sram_wdata
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            step_q, step_d;
  logic                  fixed_q, fixed_d;
  logic                  err_q, err_d;

  logic aw_hs, w_hs, last_beat, err_beat;

  // Upper address bits are outside the SRAM space and intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^AWADDR[ADDR_WIDTH-1:16];

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = WVALID && wready_q;
  assign last_beat = (cnt_q == len_q);
  // Error flag including this beat's WLAST check, so the final beat's own
  // WLAST mismatch still reaches BRESP.
  assign err_beat  = err_q || (WLAST != last_beat);

  // SRAM port is driven directly by the accepted beat.
  assign wen        = w_hs;
  assign awaddr     = addr_q;
  assign sram_wstrb = w_hs ? WSTRB : '0;
  assign sram_wdata = w_hs ? WDATA : '0;

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    fixed_d = fixed_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR[15:0];
          len_d   = AWLEN;
          cnt_d   = '0;
          fixed_d = (AWBURST == 2'd0);
          case (AWSIZE)
            3'd0:    step_d = 3'd1;
            3'd1:    step_d = 3'd2;
            default: step_d = 3'd4;
          endcase
          // Oversized beats and WRAP/reserved bursts are served as INCR
          // but reported as SLVERR.
          err_d   = (AWSIZE > 3'd2) || AWBURST[1];
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d = err_beat;
          cnt_d = cnt_q + 8'd1;
          if (!fixed_q) addr_d = addr_q + {13'd0, step_q};
          if (last_beat) begin
            state_d = RESP;
            bid_d   = id_q;
            bresp_d = err_beat ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (bvalid_q && BREADY) begin
          state_d = IDLE;
          bid_d   = '0;
          bresp_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state, so AWREADY
  // first rises one cycle after reset release.
  assign awready_d = (state_d == IDLE);
  assign wready_d  = (state_d == DATA);
  assign bvalid_d  = (state_d == RESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      id_q      <= '0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      id_q      <= id_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
    end
  end

endmodule
